uart_tx_sched: RTL

Two-requester UART transmit scheduler. It arbitrates byte requests between two clients, then sequences the shared baud-period counter and shift register to emit 8N1 frames on a single TX line. It sits between the UART's client-side byte sources and the serial pin, and replaces free-running baud tick generation with frame-aligned bit timing.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_bit_timer.sv | 40 ++++
 rtl/uart_tx_sched.sv | 121 ++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding and framing constants.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_tx_state_t;

    localparam int   DEFAULT_CLKS_PER_BIT = 414;
    localparam int   UART_DATA_BITS       = 8;
    localparam logic START_BIT            = 1'b0;
    localparam logic STOP_BIT             = 1'b1;

endpackage

// File: rtl/uart_bit_timer.sv
// Frame-aligned baud-period counter: counts clocks within one serial bit while
// a frame is running and flags the final cycle of each bit.
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic CLKIN,
    input  logic RESET,
    input  logic run,
    output logic bit_end
);

    localparam int                CNT_W   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign bit_end = (cnt_q == CNT_MAX);

    // Holding at zero while idle keeps the first bit of a frame full length.
    always_comb begin
        cnt_d = cnt_q;
        if (!run || bit_end) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge CLKIN) begin
        if (RESET) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Two-requester UART transmitter: round-robin arbitration on ties, then 8N1
// framing driven by a shared bit timer.
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       CLKIN,
    input  logic       RESET,
    input  logic       valid0,
    input  logic [7:0] data0,
    output logic       ready0,
    input  logic       valid1,
    input  logic [7:0] data1,
    output logic       ready1,
    output logic       tx,
    output logic       busy,
    output logic       owner
);

    localparam logic [2:0] LAST_BIT_IDX = 3'(UART_DATA_BITS - 1);

    uart_tx_state_t            state_q, state_d;
    logic [UART_DATA_BITS-1:0] shreg_q, shreg_d;
    logic [2:0]                bit_idx_q, bit_idx_d;
    logic                      last_grant_q, last_grant_d;
    logic                      owner_q, owner_d;

    logic bit_end;
    logic accept_window;
    logic accept;
    logic winner;

    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .CLKIN  (CLKIN),
        .RESET  (RESET),
        .run    (state_q != IDLE),
        .bit_end(bit_end)
    );

    // A tie goes to whichever requester was not granted last time.
    assign accept_window = !RESET && ((state_q == IDLE) || ((state_q == STOP) && bit_end));
    assign ready0        = accept_window && valid0 && (!valid1 || last_grant_q);
    assign ready1        = accept_window && valid1 && (!valid0 || !last_grant_q);
    assign accept        = ready0 || ready1;
    assign winner        = ready1;

    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        bit_idx_d    = bit_idx_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;

        if (accept) begin
            shreg_d      = winner ? data1 : data0;
            last_grant_d = winner;
            owner_d      = winner;
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = START;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d   = DATA;
                    bit_idx_d = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shreg_d   = shreg_q >> 1;
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == LAST_BIT_IDX) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_d = accept ? START : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        tx = STOP_BIT;
        case (state_q)
            START:   tx = START_BIT;
            DATA:    tx = shreg_q[0];
            default: tx = STOP_BIT;
        endcase
    end

    assign busy  = (state_q != IDLE);
    assign owner = owner_q;

    always_ff @(posedge CLKIN) begin
        if (RESET) begin
            state_q      <= IDLE;
            shreg_q      <= '0;
            bit_idx_q    <= '0;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            bit_idx_q    <= bit_idx_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
        end
    end

endmodule
